uart_tx_fifo: RTL and testbench

//  UART transmitter for the WGR-V peripheral bus, the counterpart of the UART receiver on uart_rx.

---
 rtl/wgr_uart_pkg.sv | 16 +
 rtl/uart_tx_fifo_if.sv | 21 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 48 ++++
 rtl/uart_tx_fifo.sv | 139 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wgr_uart_pkg.sv
// Shared definitions for the WGR-V UART transmitter and receiver.
// State encoding and baud divider helper.
package wgr_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte write handshake between the bus register file and the UART TX FIFO.
// A write happens on an edge where tx_valid && tx_ready.
interface uart_tx_fifo_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push is ignored when full,
// pop is ignored when empty. Read data is the current head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small byte FIFO; frames go out
// LSB first and back-to-back while the FIFO holds data.
module uart_tx_fifo
    import wgr_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 10000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               tx,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CPB       = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int STOP_CLKS = STOP_BITS * CPB;
    localparam int BW        = $clog2(STOP_CLKS + 1);

    if (CPB < 2) begin : g_cpb_check
        $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    uart_state_e   state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic          baud_last;
    logic          stop_last;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx.tx_valid),
        .wdata (tx.tx_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx.tx_ready = !fifo_full;
    assign busy        = (state != IDLE) || (fifo_count != '0);
    assign baud_last   = (baud_cnt == BW'(CPB - 1));
    assign stop_last   = (baud_cnt == BW'(STOP_CLKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            uart_tx  <= tx_n;
        end
    end

    // The line register follows the current state, so each bit is
    // visible one cycle after the state that produces it.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        pop     = 1'b0;
        tx_n    = 1'b1;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_rdata;
                    bit_n   = '0;
                    baud_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                tx_n = shift[0];
                if (baud_last) begin
                    baud_n  = '0;
                    shift_n = shift >> 1;
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = STOP;
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                if (stop_last) begin
                    baud_n = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_rdata;
                        bit_n   = '0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-timeline model plus
// directed scenarios and a second instance with two stop bits.
module tb_uart_tx_fifo;

    localparam int DEPTH = 8;
    localparam int CPB   = 10000000 / 115200;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst;
    always #50 clk = ~clk;

    uart_tx_fifo_if bus ();
    uart_tx_fifo_if bus2 ();

    logic       uart_tx, busy;
    logic [3:0] fifo_count;
    logic       uart_tx2, busy2;
    logic [3:0] fifo_count2;

    uart_tx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .tx         (bus),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    uart_tx_fifo #(.STOP_BITS(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .tx         (bus2),
        .uart_tx    (uart_tx2),
        .busy       (busy2),
        .fifo_count (fifo_count2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at cycle %0t",
                         nm, act, exp, $time);
        end
    endtask

    // Model: FIFO contents as a queue, plus the timeline of the last
    // frame. A byte is taken when the FIFO held data before the edge
    // and the previous frame's full length has elapsed.
    int         cyc = 0;
    logic [7:0] m_q[$];
    bit         has_frame = 0;
    int         pop_cyc = 0;
    int         next_free = 0;
    logic [7:0] m_byte = '0;

    always @(posedge clk) begin : model
        bit do_push;
        cyc++;
        if (rst) begin
            m_q.delete();
            has_frame = 0;
            next_free = 0;
        end else begin
            do_push = bus.tx_valid && (m_q.size() < DEPTH);
            if (m_q.size() > 0 && cyc >= next_free) begin
                m_byte    = m_q.pop_front();
                pop_cyc   = cyc;
                has_frame = 1;
                next_free = cyc + FRAME;
            end
            if (do_push) m_q.push_back(bus.tx_data);
        end
    end

    always @(negedge clk) begin : compare
        int   off;
        logic el;
        logic eb;
        if (cyc > 0) begin
            el = 1'b1;
            if (has_frame && cyc > pop_cyc && cyc <= pop_cyc + FRAME) begin
                off = (cyc - pop_cyc - 1) / CPB;
                if (off == 0)      el = 1'b0;
                else if (off <= 8) el = m_byte[off-1];
            end
            eb = (m_q.size() > 0) || (has_frame && cyc < pop_cyc + FRAME);
            chk("uart_tx", uart_tx, el);
            chk("busy", busy, eb);
            chk("fifo_count", fifo_count, m_q.size());
            chk("tx_ready", bus.tx_ready, m_q.size() < DEPTH);
        end
    end

    // Line decoder: mid-bit sampling, records bytes and start times.
    bit         rx_en = 0;
    logic [7:0] rx_q[$];
    int         fall_q[$];
    logic       prev_line = 1'b1;

    always begin : rx_dec
        logic [7:0] b;
        @(negedge clk);
        if (rx_en && prev_line === 1'b1 && uart_tx === 1'b0) begin
            fall_q.push_back(cyc);
            repeat (CPB / 2) @(negedge clk);
            chk("rx_start_bit", uart_tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            chk("rx_stop_bit", uart_tx, 1'b1);
            rx_q.push_back(b);
        end
        prev_line = uart_tx;
    end

    task automatic wait_idle(input int max);
        int n = 0;
        while ((busy !== 1'b0 || uart_tx !== 1'b1) && n < max) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("idle_timeout", n < max, 1'b1);
    endtask

    task automatic burst(input logic [7:0] d[$]);
        @(negedge clk);
        bus.tx_valid = 1'b1;
        foreach (d[i]) begin
            bus.tx_data = d[i];
            @(negedge clk);
        end
        bus.tx_valid = 1'b0;
    endtask

    task automatic run_len2(input logic lvl, output int n);
        n = 0;
        while (uart_tx2 === lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin : stim
        int         lat;
        int         n;
        logic [9:0] got;
        logic [7:0] d[$];
        logic [7:0] r;

        rst = 1'b1;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus2.tx_valid = 1'b0;
        bus2.tx_data  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", uart_tx, 1'b1);
        chk("rst_tx_ready", bus.tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fifo_count", fifo_count, 0);
        rst = 1'b0;
        rx_en = 1;
        repeat (2) @(negedge clk);

        // Single byte 0x42: latency, line pattern, busy release
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h42;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        lat = 0;
        while (uart_tx === 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("start_latency", lat, 2);
        repeat (CPB / 2) @(negedge clk);
        got[9] = uart_tx;
        for (int i = 1; i < 10; i++) begin
            repeat (CPB) @(negedge clk);
            got[9-i] = uart_tx;
        end
        chk("frame_0x42", got, 10'b0010000101);
        wait_idle(200);
        chk("rx_count_single", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            chk("rx_byte_single", r, 8'h42);
        end

        // Burst of ten writes: ninth fills the FIFO, tenth is dropped
        rx_q.delete();
        fall_q.delete();
        @(negedge clk);
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.tx_data = 8'h42 + 8'(i);
            @(negedge clk);
            if (i == 8) begin
                chk("burst_ready_full", bus.tx_ready, 1'b0);
                chk("burst_count_full", fifo_count, 8);
            end
        end
        bus.tx_valid = 1'b0;
        chk("burst_drop_count", fifo_count, 8);
        wait_idle(10 * FRAME);
        chk("burst_rx_count", rx_q.size(), 9);
        for (int i = 0; i < rx_q.size(); i++)
            chk("burst_rx_byte", rx_q[i], 8'h42 + 8'(i));
        for (int i = 0; i + 1 < fall_q.size(); i++)
            chk("burst_frame_gap", fall_q[i+1] - fall_q[i], FRAME);

        // Loopback-style decode of edge patterns
        rx_q.delete();
        d = '{8'h00, 8'hFF, 8'h55, 8'hAA};
        burst(d);
        wait_idle(6 * FRAME);
        chk("loop_rx_count", rx_q.size(), 4);
        for (int i = 0; i < rx_q.size() && i < 4; i++)
            chk("loop_rx_byte", rx_q[i], d[i]);

        // Reset in the middle of data bit 3 of 0xA5
        rx_en = 0;
        d = '{8'hA5, 8'h3C};
        burst(d);
        lat = 0;
        while (uart_tx === 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("a5_start_seen", lat < 10, 1'b1);
        repeat (4 * CPB + 40) @(negedge clk);
        chk("a5_bit3_level", uart_tx, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_uart_tx", uart_tx, 1'b1);
        chk("midrst_fifo_count", fifo_count, 0);
        chk("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) n++;
        end
        chk("midrst_line_quiet", n, 0);

        // Two stop bits on the second instance
        @(negedge clk);
        bus2.tx_valid = 1'b1;
        bus2.tx_data  = 8'h01;
        repeat (2) @(negedge clk);
        bus2.tx_valid = 1'b0;
        lat = 0;
        while (uart_tx2 === 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("sb2_latency", lat, 1);
        run_len2(1'b0, n);
        chk("sb2_start_len", n, CPB);
        run_len2(1'b1, n);
        chk("sb2_bit0_len", n, CPB);
        run_len2(1'b0, n);
        chk("sb2_bits_low_len", n, 7 * CPB);
        run_len2(1'b1, n);
        chk("sb2_stop_len", n, 2 * CPB);
        n = 0;
        while (busy2 !== 1'b0 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("sb2_idle_timeout", n < 2 * FRAME, 1'b1);
        repeat (CPB) @(negedge clk);
        chk("sb2_final_line", uart_tx2, 1'b1);
        chk("sb2_final_count", fifo_count2, 0);
        chk("sb2_final_ready", bus2.tx_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
